// File: rtl/subtractor_pkg.sv
// Shared types and configuration checks for the digit-serial subtractor.
package subtractor_pkg;

  typedef enum logic {
    SUB_MODE = 1'b0,
    ABS_MODE = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic bit cfg_ok(input int nb_bit, input int nb_digit);
    return (nb_digit > 0) && (nb_bit >= nb_digit) && (nb_bit % nb_digit == 0);
  endfunction

endpackage

// File: rtl/subtractor_digit.sv
// Combinational nb_digit-bit subtract slice with borrow in/out.
module subtractor_digit #(
  parameter int nb_digit = 2
) (
  input  logic [nb_digit-1:0] a_i,
  input  logic [nb_digit-1:0] b_i,
  input  logic                borrow_i,
  output logic [nb_digit-1:0] diff_o,
  output logic                borrow_o
);

  // The extra MSB of the widened difference is set exactly when the slice underflows.
  logic [nb_digit:0] full;

  assign full     = {1'b0, a_i} - {1'b0, b_i} - {{nb_digit{1'b0}}, borrow_i};
  assign diff_o   = full[nb_digit-1:0];
  assign borrow_o = full[nb_digit];

endmodule

// File: rtl/subtractor_seq.sv
// Digit-serial unsigned subtractor with optional |a-b| pass; one digit slice is
// shared by the subtract pass and the serial negation pass.
module subtractor_seq
  import subtractor_pkg::*;
#(
  parameter int nb_bit   = 8,
  parameter int nb_digit = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);

  localparam int N     = nb_bit / nb_digit;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!cfg_ok(nb_bit, nb_digit)) begin : g_cfg_err
    $error("subtractor_seq: nb_bit must be a positive multiple of nb_digit");
  end

  state_t              state, state_d;
  mode_t               mode_q;
  logic [nb_bit-1:0]   a_sr, b_sr, res_sr, res_shift;
  logic [CNT_W-1:0]    cnt;
  logic                borrow_q, sign_q, last_step;
  logic [nb_digit-1:0] op_a, op_b, dig;
  logic                dig_borrow;

  // NEG reuses the slice as 0 - res, consuming the result register LSB-first.
  always_comb begin
    op_a      = (state == NEG) ? '0 : a_sr[nb_digit-1:0];
    op_b      = (state == NEG) ? res_sr[nb_digit-1:0] : b_sr[nb_digit-1:0];
    last_step = (cnt == LAST);
    res_shift = (res_sr >> nb_digit) | (nb_bit'(dig) << (nb_bit - nb_digit));
  end

  subtractor_digit #(.nb_digit(nb_digit)) u_digit (
    .a_i      (op_a),
    .b_i      (op_b),
    .borrow_i (borrow_q),
    .diff_o   (dig),
    .borrow_o (dig_borrow)
  );

  always_comb begin
    state_d = state;
    busy_o  = (state != IDLE);
    case (state)
      IDLE: if (start_i) state_d = SUB;
      SUB:  if (last_step) state_d = (mode_q == ABS_MODE && dig_borrow) ? NEG : DONE;
      NEG:  if (last_step) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
      sign_q   <= 1'b0;
      mode_q   <= SUB_MODE;
      diff_o   <= '0;
      borrow_o <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sr     <= a_i;
            b_sr     <= b_i;
            mode_q   <= mode_t'(mode_i);
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        SUB: begin
          a_sr   <= a_sr >> nb_digit;
          b_sr   <= b_sr >> nb_digit;
          res_sr <= res_shift;
          if (last_step) begin
            // Borrow chain restarts clean for a possible negation pass.
            sign_q   <= dig_borrow;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end else begin
            borrow_q <= dig_borrow;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        NEG: begin
          res_sr   <= res_shift;
          borrow_q <= dig_borrow;
          cnt      <= last_step ? '0 : cnt + CNT_W'(1);
        end
        DONE: begin
          diff_o   <= res_sr;
          borrow_o <= sign_q;
          done_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_seq.sv
// Self-checking bench: three instances (nb_digit 1, 2, 8) against an arithmetic model.
module tb_subtractor_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic       mode;
  logic [7:0] a, b;
  logic [2:0] busy, done, brw;
  logic [7:0] diff [3];

  int n_steps [3] = '{8, 4, 1};
  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  int         done_cnt [3] = '{0, 0, 0};
  int         done_cyc [3];
  logic [7:0] cap_diff [3];
  logic       cap_br   [3];
  int         cnt0     [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  subtractor_seq #(.nb_bit(8), .nb_digit(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .mode_i(mode), .a_i(a), .b_i(b),
    .busy_o(busy[0]), .done_o(done[0]), .diff_o(diff[0]), .borrow_o(brw[0]));
  subtractor_seq #(.nb_bit(8), .nb_digit(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .mode_i(mode), .a_i(a), .b_i(b),
    .busy_o(busy[1]), .done_o(done[1]), .diff_o(diff[1]), .borrow_o(brw[1]));
  subtractor_seq #(.nb_bit(8), .nb_digit(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .mode_i(mode), .a_i(a), .b_i(b),
    .busy_o(busy[2]), .done_o(done[2]), .diff_o(diff[2]), .borrow_o(brw[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        cap_diff[i] = diff[i];
        cap_br[i]   = brw[i];
      end
    end
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [7:0] ma, mb, input logic mm, input int n,
                                output logic [7:0] md, output logic mbr, output int lat);
    int d;
    d = int'(ma) - int'(mb);
    mbr = (ma < mb);
    if (mm && d < 0) d = -d;
    md  = 8'((d + 256) % 256);
    lat = (mm && ma < mb) ? 2 * n + 1 : n + 1;
  endfunction

  task automatic launch(input logic [2:0] mask, input logic [7:0] aa, bb, input logic mm,
                        output int c0);
    for (int i = 0; i < 3; i++) cnt0[i] = done_cnt[i];
    @(negedge clk);
    a = aa; b = bb; mode = mm; start = mask;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    start = 3'b000;
  endtask

  task automatic wait_done(input logic [2:0] mask, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if ((!mask[0] || done_cnt[0] != cnt0[0]) && (!mask[1] || done_cnt[1] != cnt0[1]) &&
          (!mask[2] || done_cnt[2] != cnt0[2])) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 3'b000; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], brw[i], diff[i]} !== 11'd0) begin
        fails++;
        $display("FAIL reset_outputs inst=%0d busy=%b done=%b borrow=%b diff=%h required all 0",
                 i, busy[i], done[i], brw[i], diff[i]);
      end else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [7:0] va [4] = '{8'hA5, 8'h3C, 8'h3C, 8'h80};
    logic [7:0] vb [4] = '{8'h3C, 8'hA5, 8'hA5, 8'h80};
    logic       vm [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] xd [4] = '{8'h69, 8'h97, 8'h69, 8'h00};
    logic       xb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int         xl [4] = '{5, 5, 9, 5};
    int c0;
    bit ok;
    for (int v = 0; v < 4; v++) begin
      launch(3'b010, va[v], vb[v], vm[v], c0);
      wait_done(3'b010, ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL vec%0d_timeout no done_o within 40 cycles", v);
        continue;
      end else passed++;
      checks++;
      if (cap_diff[1] !== xd[v] || cap_br[1] !== xb[v]) begin
        fails++;
        $display("FAIL vec%0d_result diff=%h borrow=%b required diff=%h borrow=%b",
                 v, cap_diff[1], cap_br[1], xd[v], xb[v]);
      end else passed++;
      checks++;
      if (done_cyc[1] - c0 !== xl[v]) begin
        fails++;
        $display("FAIL vec%0d_latency got %0d required %0d", v, done_cyc[1] - c0, xl[v]);
      end else passed++;
      @(negedge clk); #1;
      checks++;
      if (done[1] !== 1'b0 || done_cnt[1] - cnt0[1] !== 1) begin
        fails++;
        $display("FAIL vec%0d_pulse done=%b pulses=%0d required done=0 pulses=1",
                 v, done[1], done_cnt[1] - cnt0[1]);
      end else passed++;
    end
  endtask

  task automatic test_ignore_start;
    int c0;
    launch(3'b010, 8'hA5, 8'h3C, 1'b0, c0);
    @(negedge clk);
    a = 8'h11; b = 8'h22; mode = 1'b1; start = 3'b010;
    @(negedge clk);
    start = 3'b000;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt[1] - cnt0[1] !== 1 || cap_diff[1] !== 8'h69 || cap_br[1] !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start pulses=%0d diff=%h borrow=%b required pulses=1 diff=69 borrow=0",
               done_cnt[1] - cnt0[1], cap_diff[1], cap_br[1]);
    end else passed++;
  endtask

  task automatic test_reset_mid;
    int c0;
    bit ok;
    launch(3'b010, 8'h3C, 8'hA5, 1'b0, c0);
    wait_done(3'b010, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok || diff[1] !== 8'h97 || brw[1] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_result ok=%b diff=%h borrow=%b required diff=97 borrow=1",
               ok, diff[1], brw[1]);
    end else passed++;
    launch(3'b010, 8'h3C, 8'hA5, 1'b1, c0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy[1], done[1], brw[1], diff[1]} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs busy=%b done=%b borrow=%b diff=%h required all 0",
               busy[1], done[1], brw[1], diff[1]);
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt[1] !== cnt0[1]) begin
      fails++;
      $display("FAIL reset_mid_no_done pulses=%0d required 0", done_cnt[1] - cnt0[1]);
    end else passed++;
  endtask

  task automatic test_sweep;
    logic [7:0] corner [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    logic [7:0] ra, rb, md;
    logic       rm, mbr;
    int lat, c0;
    bit ok;
    for (int it = 0; it < 1000; it++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 3)];
      rm = 1'($urandom);
      launch(3'b111, ra, rb, rm, c0);
      wait_done(3'b111, ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL sweep_timeout it=%0d a=%h b=%h mode=%b", it, ra, rb, rm);
        continue;
      end else passed++;
      for (int i = 0; i < 3; i++) begin
        model(ra, rb, rm, n_steps[i], md, mbr, lat);
        checks++;
        if (cap_diff[i] !== md || cap_br[i] !== mbr || done_cyc[i] - c0 !== lat) begin
          fails++;
          $display("FAIL sweep inst=%0d a=%h b=%h mode=%b diff=%h borrow=%b lat=%0d required diff=%h borrow=%b lat=%0d",
                   i, ra, rb, rm, cap_diff[i], cap_br[i], done_cyc[i] - c0, md, mbr, lat);
        end else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/subtractor_seq.md
# subtractor_seq

Parametrised, digit-serial unsigned subtractor with a start/done handshake. It computes a_i − b_i over nb_bit bits, processing nb_digit bits per clock from the LSB upward through a registered borrow chain. An optional absolute-difference mode adds a second serial negation pass. It sits beside the combinational subtractor_n in arithmetic datapaths that trade latency for area.

## Interface
- nb_bit, default 8: operand/result width; must be a multiple of nb_digit.
- nb_digit, default 2: bits processed per step; N = nb_bit/nb_digit steps per pass.
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- mode_i  in  1  0 = SUB (a−b modulo 2^nb_bit), 1 = ABS (|a−b|); captured with start.
- a_i  in  nb_bit  minuend; captured with start.
- b_i  in  nb_bit  subtrahend; captured with start.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle pulse when the result is valid.
- diff_o  out  nb_bit  result; SUB: a−b mod 2^nb_bit; ABS: |a−b|.
- borrow_o  out  1  1 if a_i < b_i (both modes).

## Operation
- FSM states: IDLE, SUB, NEG, DONE.
- IDLE: on start_i=1, capture a_i, b_i, mode_i into shift registers; clear the borrow register and digit counter; go to SUB. start_i=0 keeps IDLE.
- SUB, one step per edge:
  - Subtract the low nb_digit bits of the operand registers with the registered borrow.
  - Shift the result digit in at the MSB end of the result shift register.
  - Update the borrow register and increment the counter.
- SUB exit, after step N:
  - If mode=ABS and the final borrow is 1, latch sign=1 and go to NEG.
  - Otherwise latch the final borrow as sign and go to DONE.
- NEG: serially compute 0 − result, N steps, using the same digit slice and borrow chain cleared at entry. Go to DONE after step N. sign is unchanged.
- DONE: diff_o ← result register, borrow_o ← sign, done_o=1 for exactly this cycle. Next edge goes to IDLE.
- start_i outside IDLE is ignored; no queuing.
- diff_o and borrow_o change only when entering DONE and hold until the next completion.
- Width rule: the borrow register is 1 bit. ABS magnitude is always ≤ 2^nb_bit−1, so no overflow is possible.

## Timing
- Reset values: busy_o=0, done_o=0, diff_o=0, borrow_o=0, state IDLE, internal registers 0.
- Start is accepted at edge 0.
- Done timing:
  - SUB, or ABS with a≥b: done_o high in the cycle after edge N+1, i.e. N+1 cycles after acceptance.
  - ABS with a<b: done_o high after edge 2N+1.
- busy_o rises after edge 0 and falls after the edge that leaves DONE. The earliest next start is accepted one cycle after done_o.
- rst_i mid-operation (any state) returns everything to reset values on that edge. No done_o is emitted, and the partial result is discarded.
- rst_i and start_i high together: reset wins.
- nb_digit = nb_bit gives N=1. Single-step passes still go through DONE.

## Structure
- Shared package subtractor_pkg:
  - mode_t enum (SUB_MODE=0, ABS_MODE=1).
  - state_t enum (IDLE, SUB, NEG, DONE).
  - Elaboration-time check that nb_bit % nb_digit == 0.
- Sub-module subtractor_digit: combinational nb_digit-bit subtractor with borrow_i/borrow_o. It is instantiated once and shared by the SUB and NEG passes.

## Test plan
All cases use nb_bit=8, nb_digit=2 (N=4) unless noted.
- SUB a=0xA5, b=0x3C → diff_o=0x69, borrow_o=0; done_o pulses exactly 5 cycles after start acceptance, single cycle.
- SUB a=0x3C, b=0xA5 → diff_o=0x97, borrow_o=1; done after 5 cycles.
- ABS a=0x3C, b=0xA5 → diff_o=0x69, borrow_o=1; done after 9 cycles.
- ABS a=b=0x80 → diff_o=0x00, borrow_o=0; done after 5 cycles.
- Second start_i pulse while busy is ignored (one done only).
- rst_i asserted at step 2 → all outputs 0 the next cycle and no done_o.
- Sweep nb_digit ∈ {1, 2, 8} with 1000 random operand/mode pairs → diff_o and borrow_o match the reference model, and latency matches the formula.
